// File: rtl/hangman_datapath.sv
// Hangman datapath: holds the secret word, evaluates guesses, reveals letters and counts parts.
// Define REPEAT_GUESS_EN to track used letters; the repeat flag is the port `repeated`.
module hangman_datapath #(
    parameter int unsigned MAX_LEN   = 8,
    parameter int unsigned CHAR_W    = 5,
    parameter int unsigned MAX_PARTS = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ld,
    input  logic               compare,
    input  logic               fill,
    input  logic               draw,
    input  logic               wipe,
    input  logic [CHAR_W-1:0]  char_in,
    output logic               match,
    output logic               filled,
    output logic               cont,
    output logic               finish,
    output logic               complete,
    output logic [3:0]         part,
    output logic [3:0]         word_len,
    output logic [MAX_LEN-1:0] reveal,
    output logic               full,
    output logic               repeated
);

    typedef enum logic {StIdle, StScan} state_e;

    state_e state_q, state_d;
    logic ld_q, compare_q, fill_q, draw_q;
    logic ld_rise, compare_rise, fill_rise, draw_rise;
    logic [CHAR_W-1:0] word_q [MAX_LEN];
    logic [CHAR_W-1:0] word_d [MAX_LEN];
    logic [CHAR_W-1:0] guess_q, guess_d;
    logic [3:0] len_q, len_d, idx_q, idx_d, part_q, part_d;
    logic [MAX_LEN-1:0] reveal_q, reveal_d, valid_mask;
    logic lock_q, lock_d, match_q, match_d, filled_q, filled_d;
    logic cont_q, cont_d, finish_q, finish_d, rep_q, rep_d;
    logic char_hit;
`ifdef REPEAT_GUESS_EN
    logic [25:0] used_q, used_d;
`endif

    assign ld_rise      = ld & ~ld_q;
    assign compare_rise = compare & ~compare_q;
    assign fill_rise    = fill & ~fill_q;
    assign draw_rise    = draw & ~draw_q;

    always_comb begin
        char_hit   = 1'b0;
        valid_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            valid_mask[i] = (i < 32'(len_q));
            if (valid_mask[i] && word_q[i] == char_in) char_hit = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        guess_d  = guess_q;
        len_d    = len_q;
        idx_d    = idx_q;
        part_d   = part_q;
        reveal_d = reveal_q;
        lock_d   = lock_q;
        match_d  = match_q;
        cont_d   = cont_q;
        rep_d    = rep_q;
        filled_d = 1'b0;
        finish_d = 1'b0;
`ifdef REPEAT_GUESS_EN
        used_d   = used_q;
`endif
        if (wipe) begin
            state_d  = StIdle;
            word_d   = '{default: '0};
            guess_d  = '0;
            len_d    = '0;
            idx_d    = '0;
            part_d   = '0;
            reveal_d = '0;
            lock_d   = 1'b0;
            match_d  = 1'b0;
            cont_d   = 1'b0;
            rep_d    = 1'b0;
`ifdef REPEAT_GUESS_EN
            used_d   = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // One command per cycle: compare > fill > draw > ld
                    if (compare_rise) begin
                        guess_d = char_in;
                        lock_d  = 1'b1;
                        match_d = char_hit;
                        rep_d   = 1'b0;
`ifdef REPEAT_GUESS_EN
                        for (int unsigned c = 0; c < 26; c++) begin
                            if (32'(char_in) == c) begin
                                if (used_q[c]) begin
                                    rep_d   = 1'b1;
                                    match_d = 1'b0;
                                end else begin
                                    used_d[c] = 1'b1;
                                end
                            end
                        end
`endif
                    end else if (fill_rise) begin
                        if (len_q == 4'd0) begin
                            filled_d = 1'b1;
                            cont_d   = 1'b0;
                        end else begin
                            state_d = StScan;
                            idx_d   = '0;
                        end
                    end else if (draw_rise) begin
                        if (32'(part_q) < MAX_PARTS) part_d = part_q + 4'd1;
                        finish_d = 1'b1;
                    end else if (ld_rise && !lock_q && !full) begin
                        for (int unsigned i = 0; i < MAX_LEN; i++) begin
                            if (32'(len_q) == i) word_d[i] = char_in;
                        end
                        len_d = len_q + 4'd1;
                    end
                end
                StScan: begin
                    for (int unsigned i = 0; i < MAX_LEN; i++) begin
                        if (32'(idx_q) == i && word_q[i] == guess_q) reveal_d[i] = 1'b1;
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_d == len_q) begin
                        state_d  = StIdle;
                        filled_d = 1'b1;
                        cont_d   = |(~reveal_d & valid_mask);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            ld_q      <= 1'b0;
            compare_q <= 1'b0;
            fill_q    <= 1'b0;
            draw_q    <= 1'b0;
            word_q    <= '{default: '0};
            guess_q   <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            part_q    <= '0;
            reveal_q  <= '0;
            lock_q    <= 1'b0;
            match_q   <= 1'b0;
            filled_q  <= 1'b0;
            cont_q    <= 1'b0;
            finish_q  <= 1'b0;
            rep_q     <= 1'b0;
`ifdef REPEAT_GUESS_EN
            used_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ld_q      <= ld;
            compare_q <= compare;
            fill_q    <= fill;
            draw_q    <= draw;
            word_q    <= word_d;
            guess_q   <= guess_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            part_q    <= part_d;
            reveal_q  <= reveal_d;
            lock_q    <= lock_d;
            match_q   <= match_d;
            filled_q  <= filled_d;
            cont_q    <= cont_d;
            finish_q  <= finish_d;
            rep_q     <= rep_d;
`ifdef REPEAT_GUESS_EN
            used_q    <= used_d;
`endif
        end
    end

    assign match    = match_q;
    assign filled   = filled_q;
    assign cont     = cont_q;
    assign finish   = finish_q;
    assign part     = part_q;
    assign word_len = len_q;
    assign reveal   = reveal_q;
    assign full     = (32'(len_q) == MAX_LEN);
    assign complete = (32'(part_q) == MAX_PARTS);
    assign repeated = rep_q;

endmodule

// File: tb/tb_hangman_datapath.sv
// Bench for hangman_datapath: game-level model checked every cycle plus directed literal checks.
module tb_hangman_datapath;
    localparam int MAX_LEN   = 8;
    localparam int MAX_PARTS = 6;

    logic clk = 1'b0, resetn = 1'b0;
    logic ld = 1'b0, compare = 1'b0, fill = 1'b0, draw = 1'b0, wipe = 1'b0;
    logic [4:0] char_in = '0;
    logic match, filled, cont, finish, complete, full, repeated;
    logic [3:0] part, word_len;
    logic [7:0] reveal;
    int checks = 0, errors = 0;
    int lat, seen;

    always #5 clk = ~clk;

    hangman_datapath #(.MAX_LEN(MAX_LEN), .CHAR_W(5), .MAX_PARTS(MAX_PARTS)) dut (
        .clk(clk), .resetn(resetn), .ld(ld), .compare(compare), .fill(fill), .draw(draw),
        .wipe(wipe), .char_in(char_in), .match(match), .filled(filled), .cont(cont),
        .finish(finish), .complete(complete), .part(part), .word_len(word_len),
        .reveal(reveal), .full(full), .repeated(repeated)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game-level model: word as a queue, scan modelled as a countdown to the final reveal
    int  m_word[$];
    int  m_guess, m_part, scan_left;
    bit  m_lock, m_match, m_filled, m_cont, m_finish, m_rep;
    bit  [7:0] m_reveal, m_target;
    bit  [25:0] m_used;
    bit  p_ld, p_cmp, p_fill, p_draw;
    bit  chk_en = 1'b0;

    function automatic bit [7:0] vmask(int n);
        return 8'((1 << n) - 1);
    endfunction

    task automatic m_clear();
        m_word.delete();
        m_guess = 0; m_part = 0; scan_left = 0;
        m_lock = 0; m_match = 0; m_filled = 0; m_cont = 0; m_finish = 0; m_rep = 0;
        m_reveal = '0; m_target = '0; m_used = '0;
        p_ld = 0; p_cmp = 0; p_fill = 0; p_draw = 0;
    endtask

    always @(negedge resetn) m_clear();

    always @(posedge clk) begin
        if (!resetn) begin
            m_clear();
        end else begin
            bit r_ld, r_cmp, r_fill, r_draw;
            int c;
            r_ld = ld & ~p_ld; r_cmp = compare & ~p_cmp;
            r_fill = fill & ~p_fill; r_draw = draw & ~p_draw;
            c = int'(char_in);
            m_filled = 0; m_finish = 0;
            if (wipe) begin
                m_clear();
            end else if (scan_left > 0) begin
                scan_left--;
                if (scan_left == 0) begin
                    m_reveal = m_target;
                    m_filled = 1;
                    m_cont   = (m_reveal != vmask(m_word.size()));
                end
            end else if (r_cmp) begin
                m_guess = c; m_lock = 1; m_match = 0; m_rep = 0;
                foreach (m_word[i]) if (m_word[i] == c) m_match = 1;
`ifdef REPEAT_GUESS_EN
                if (c < 26) begin
                    if (m_used[c]) begin m_rep = 1; m_match = 0; end
                    else m_used[c] = 1'b1;
                end
`endif
            end else if (r_fill) begin
                if (m_word.size() == 0) begin
                    m_filled = 1; m_cont = 0;
                end else begin
                    m_target = m_reveal;
                    foreach (m_word[i]) if (m_word[i] == m_guess) m_target[i] = 1'b1;
                    scan_left = m_word.size();
                end
            end else if (r_draw) begin
                if (m_part < MAX_PARTS) m_part++;
                m_finish = 1;
            end else if (r_ld && !m_lock && m_word.size() < MAX_LEN) begin
                m_word.push_back(c);
            end
            p_ld = ld; p_cmp = compare; p_fill = fill; p_draw = draw;
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("match", match, m_match);
            chk("filled", filled, m_filled);
            chk("finish", finish, m_finish);
            chk("part", part, m_part);
            chk("complete", complete, m_part == MAX_PARTS);
            chk("word_len", word_len, m_word.size());
            chk("full", full, m_word.size() == MAX_LEN);
            chk("repeated", repeated, m_rep);
            if (m_filled) chk("cont", cont, m_cont);
            if (scan_left == 0) chk("reveal", reveal, m_reveal);
        end
    end

    task automatic do_cmd(input int which, input logic [4:0] ch);
        @(negedge clk);
        char_in = ch;
        case (which)
            0: ld = 1'b1;
            1: compare = 1'b1;
            default: draw = 1'b1;
        endcase
        @(negedge clk);
        ld = 1'b0; compare = 1'b0; draw = 1'b0;
    endtask

    task automatic do_fill(output int l);
        @(negedge clk);
        fill = 1'b1;
        l = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            fill = 1'b0;
            if (filled) begin l = k; break; end
        end
    endtask

    task automatic do_wipe();
        @(negedge clk); wipe = 1'b1;
        @(negedge clk); wipe = 1'b0;
    endtask

    task automatic load_cat();
        do_cmd(0, 5'd2); do_cmd(0, 5'd0); do_cmd(0, 5'd19);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_match", match, 0); chk("rst_part", part, 0);
        chk("rst_len", word_len, 0); chk("rst_reveal", reveal, 0); chk("rst_full", full, 0);
        resetn = 1'b1;
        chk_en = 1'b1;

        // CAT, guess A, reveal position 1
        load_cat();
        chk("t1_len", word_len, 3); chk("t1_full", full, 0);
        do_cmd(1, 5'd0);
        chk("t1_match", match, 1);
        do_fill(lat);
        chk("t1_lat", lat, 4); chk("t1_reveal", reveal, 8'b0000_0010); chk("t1_cont", cont, 1);

        // Miss then draws to saturation
        do_cmd(1, 5'd25);
        chk("t2_match", match, 0);
        for (int d = 0; d < 7; d++) begin
            do_cmd(2, 5'd0);
            chk("t2_finish", finish, 1);
        end
        chk("t2_part", part, 6); chk("t2_complete", complete, 1);

        // fill beats a simultaneous draw; draws during scan dropped
        do_wipe(); load_cat(); do_cmd(1, 5'd2);
        @(negedge clk); fill = 1'b1; draw = 1'b1;
        @(negedge clk); fill = 1'b0; draw = 1'b0;
        @(negedge clk); draw = 1'b1;
        @(negedge clk); draw = 1'b0;
        repeat (4) @(negedge clk);
        chk("prio_part", part, 0); chk("prio_reveal", reveal, 8'b0000_0001);

        // compare beats a simultaneous ld
        do_wipe();
        @(negedge clk); ld = 1'b1; compare = 1'b1; char_in = 5'd4;
        @(negedge clk); ld = 1'b0; compare = 1'b0;
        chk("prio_len", word_len, 0); chk("prio_match", match, 0);

        // Empty word fill
        do_wipe(); do_fill(lat);
        chk("t0_lat", lat, 1); chk("t0_cont", cont, 0);

        // Overflow and lock
        do_wipe();
        for (int i = 0; i < 9; i++) do_cmd(0, 5'(i));
        chk("t3_len", word_len, 8); chk("t3_full", full, 1);
        do_cmd(1, 5'd0); chk("t3_match", match, 1);
        do_wipe(); do_cmd(0, 5'd0); do_cmd(1, 5'd0); do_cmd(0, 5'd1);
        chk("t3_lock", word_len, 1);

        // Reveal whole word
        do_wipe(); load_cat();
        do_cmd(1, 5'd2); do_fill(lat); chk("t4_cont1", cont, 1);
        do_cmd(1, 5'd0); do_fill(lat);
        do_cmd(1, 5'd19); do_fill(lat);
        chk("t4_lat", lat, 4); chk("t4_cont", cont, 0); chk("t4_reveal", reveal, 8'b0000_0111);

        // wipe mid-scan
        do_wipe(); load_cat(); do_cmd(1, 5'd0);
        @(negedge clk); fill = 1'b1;
        @(negedge clk); fill = 1'b0;
        @(negedge clk); wipe = 1'b1;
        @(negedge clk); wipe = 1'b0;
        chk("t5_len", word_len, 0); chk("t5_reveal", reveal, 0); chk("t5_filled", filled, 0);
        seen = 0;
        repeat (6) begin @(negedge clk); if (filled) seen++; end
        chk("t5_nofill", seen, 0);

        // async reset mid-scan
        load_cat(); do_cmd(1, 5'd0);
        @(negedge clk); fill = 1'b1;
        @(negedge clk); fill = 1'b0;
        @(posedge clk); #3 resetn = 1'b0;
        #1;
        chk("t5r_len", word_len, 0); chk("t5r_match", match, 0); chk("t5r_lock_len", full, 0);
        @(negedge clk); @(negedge clk); resetn = 1'b1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (filled) seen++; end
        chk("t5r_nofill", seen, 0);

        // Repeated guess
        load_cat(); do_cmd(1, 5'd0); do_cmd(1, 5'd0);
`ifdef REPEAT_GUESS_EN
        chk("t6_rep", repeated, 1); chk("t6_match", match, 0);
        do_cmd(1, 5'd27); do_cmd(1, 5'd27);
        chk("t6_rep_hi", repeated, 0);
`else
        chk("t6_rep", repeated, 0); chk("t6_match", match, 1);
`endif
        do_cmd(1, 5'd2);
        chk("t6_rep_new", repeated, 0); chk("t6_match_new", match, 1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
